// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared types and constants for the forwarding/hazard unit
package fwd_hazard_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_W      = 3;
  localparam int FWD_DEPTH  = 3;
  localparam int LANES      = 2;
  localparam int LANE_B     = 0;
  localparam int LANE_M     = 1;

  typedef enum logic [FWD_W-1:0] {
    FWD_NORMAL = 3'b000,
    FWD_B_EX   = 3'b001,
    FWD_M_EX   = 3'b010,
    FWD_B_MEM  = 3'b011,
    FWD_M_MEM  = 3'b100,
    FWD_B_WB   = 3'b101,
    FWD_M_WB   = 3'b110
  } fwd_mode_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } fwd_entry_t;

  // Index [age][lane]; age 0 is the bundle issued one cycle ago.
  typedef fwd_entry_t [LANES-1:0]   fwd_age_t;
  typedef fwd_age_t [FWD_DEPTH-1:0] fwd_track_t;

  function automatic logic entry_match(input fwd_entry_t e, input logic [REG_ADDR_W-1:0] src);
    return e.valid && e.regwrite && (e.rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - youngest-producer-first forwarding mode select for one source operand
module fwd_select
  import fwd_hazard_unit_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  fwd_track_t            track,
  output fwd_mode_t             mode
);

  logic unused_load;
  always_comb begin
    unused_load = 1'b0;
    for (int a = 0; a < FWD_DEPTH; a++) begin
      for (int l = 0; l < LANES; l++) begin
        unused_load = unused_load ^ track[a][l].is_load;
      end
    end
  end

  // Within an age the Memory lane is the younger slot, so it is checked first.
  always_comb begin
    mode = FWD_NORMAL;
    if (entry_match(track[0][LANE_M], src))      mode = FWD_M_EX;
    else if (entry_match(track[0][LANE_B], src)) mode = FWD_B_EX;
    else if (entry_match(track[1][LANE_M], src)) mode = FWD_M_MEM;
    else if (entry_match(track[1][LANE_B], src)) mode = FWD_B_MEM;
    else if (entry_match(track[2][LANE_M], src)) mode = FWD_M_WB;
    else if (entry_match(track[2][LANE_B], src)) mode = FWD_B_WB;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - destination tracker, registered forwarding selects and load-use stall
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ID_Valid_B,
  input  logic                  ID_Valid_M,
  input  logic [REG_ADDR_W-1:0] ID_Rd_B,
  input  logic [REG_ADDR_W-1:0] ID_Rd_M,
  input  logic                  ID_RegWrite_B,
  input  logic                  ID_RegWrite_M,
  input  logic                  ID_IsLoad_M,
  input  logic [REG_ADDR_W-1:0] ID_Rs1_B,
  input  logic [REG_ADDR_W-1:0] ID_Rs2_B,
  input  logic [REG_ADDR_W-1:0] ID_Rs1_M,
  input  logic [REG_ADDR_W-1:0] ID_Rs2_M,
  input  logic                  Hold,
  input  logic                  Flush,
  output logic [FWD_W-1:0]      Fwd_Rs1_B,
  output logic [FWD_W-1:0]      Fwd_Rs2_B,
  output logic [FWD_W-1:0]      Fwd_Rs1_M,
  output logic [FWD_W-1:0]      Fwd_Rs2_M,
  output logic                  Load_Use_Stall
);

  fwd_track_t track;
  fwd_age_t   dec_age;
  fwd_mode_t  sel_rs1_b, sel_rs2_b, sel_rs1_m, sel_rs2_m;
  fwd_mode_t  mode_rs1_b, mode_rs2_b, mode_rs1_m, mode_rs2_m;
  logic       load_hit;

  always_comb begin
    dec_age = '0;
    if (ID_Valid_B) begin
      dec_age[LANE_B] = '{valid: 1'b1, rd: ID_Rd_B, regwrite: ID_RegWrite_B, is_load: 1'b0};
    end
    if (ID_Valid_M) begin
      dec_age[LANE_M] = '{valid: 1'b1, rd: ID_Rd_M, regwrite: ID_RegWrite_M, is_load: ID_IsLoad_M};
    end
  end

  fwd_select u_sel_rs1_b (.src(ID_Rs1_B), .track(track), .mode(sel_rs1_b));
  fwd_select u_sel_rs2_b (.src(ID_Rs2_B), .track(track), .mode(sel_rs2_b));
  fwd_select u_sel_rs1_m (.src(ID_Rs1_M), .track(track), .mode(sel_rs1_m));
  fwd_select u_sel_rs2_m (.src(ID_Rs2_M), .track(track), .mode(sel_rs2_m));

  // A load result is not available to Execute one cycle later; only valid slots consume.
  always_comb begin
    load_hit = 1'b0;
    if (track[0][LANE_M].valid && track[0][LANE_M].is_load) begin
      load_hit = (ID_Valid_B && (entry_match(track[0][LANE_M], ID_Rs1_B) ||
                                 entry_match(track[0][LANE_M], ID_Rs2_B))) ||
                 (ID_Valid_M && (entry_match(track[0][LANE_M], ID_Rs1_M) ||
                                 entry_match(track[0][LANE_M], ID_Rs2_M)));
    end
  end

  assign Load_Use_Stall = !Hold && !Flush && load_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      track      <= '0;
      mode_rs1_b <= FWD_NORMAL;
      mode_rs2_b <= FWD_NORMAL;
      mode_rs1_m <= FWD_NORMAL;
      mode_rs2_m <= FWD_NORMAL;
    end else if (!Hold) begin
      track[2] <= track[1];
      if (Flush) begin
        // The bundle issued last cycle is killed too, so it never reaches age 2.
        track[1]   <= '0;
        track[0]   <= '0;
        mode_rs1_b <= FWD_NORMAL;
        mode_rs2_b <= FWD_NORMAL;
        mode_rs1_m <= FWD_NORMAL;
        mode_rs2_m <= FWD_NORMAL;
      end else if (Load_Use_Stall) begin
        track[1]   <= track[0];
        track[0]   <= '0;
        mode_rs1_b <= FWD_NORMAL;
        mode_rs2_b <= FWD_NORMAL;
        mode_rs1_m <= FWD_NORMAL;
        mode_rs2_m <= FWD_NORMAL;
      end else begin
        track[1]   <= track[0];
        track[0]   <= dec_age;
        mode_rs1_b <= sel_rs1_b;
        mode_rs2_b <= sel_rs2_b;
        mode_rs1_m <= sel_rs1_m;
        mode_rs2_m <= sel_rs2_m;
      end
    end
  end

  assign Fwd_Rs1_B = mode_rs1_b;
  assign Fwd_Rs2_B = mode_rs2_b;
  assign Fwd_Rs1_M = mode_rs1_m;
  assign Fwd_Rs2_M = mode_rs2_m;

endmodule
